// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and baud-select codes, TX state encoding and divisor math.
// The receiver's error check decodes ParityType with the same PAR_* codes.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    // start + 8 data + parity + stop; the parity slot is sent even when parity is off
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Clocks per bit, rounded to nearest: round(clk_freq / (2400 << sel)).
    function automatic int baud_div(input int clk_freq, input logic [1:0] sel);
        int rate;
        rate = 2400 << sel;
        return (clk_freq + rate / 2) / rate;
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] ptype);
        logic p;
        p = 1'b1;
        if (ptype == PAR_ODD) begin
            p = ~^data;
        end else if (ptype == PAR_EVEN) begin
            p = ^data;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: BitTick pulses for one clock every DIV clocks while enabled.
// Counter is held at zero when disabled so the first bit after enable is a full period.
module uart_tx_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int DIV_W    = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       enable,
    input  logic [1:0] baud_sel,
    output logic       BitTick
);

    localparam logic [DIV_W-1:0] DIV_2400  = DIV_W'(baud_div(CLK_FREQ, BAUD_2400));
    localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(baud_div(CLK_FREQ, BAUD_4800));
    localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(baud_div(CLK_FREQ, BAUD_9600));
    localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(baud_div(CLK_FREQ, BAUD_19200));

    logic [DIV_W-1:0] div_last;
    logic [DIV_W-1:0] cnt;

    always_comb begin
        div_last = DIV_2400 - DIV_W'(1);
        case (baud_sel)
            BAUD_2400:  div_last = DIV_2400 - DIV_W'(1);
            BAUD_4800:  div_last = DIV_4800 - DIV_W'(1);
            BAUD_9600:  div_last = DIV_9600 - DIV_W'(1);
            BAUD_19200: div_last = DIV_19200 - DIV_W'(1);
            default: ;
        endcase
    end

    assign BitTick = enable && (cnt == div_last);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (!enable || BitTick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: Send/Busy handshake, 11-bit frame (start, 8 data LSB-first, parity, stop).
// Frame starts on the accept edge and lasts 11*DIV clocks; Send while Busy is dropped, not queued.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int DIV_W    = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Send,
    input  logic [7:0] DataIn,
    input  logic [1:0] ParityType,
    input  logic [1:0] BaudRate,
    output logic       DataTx,
    output logic       Busy,
    output logic       Done
);

    localparam int DATA_BITS = FRAME_BITS - 3;

    tx_state_t  state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       par_bit;
    logic [1:0] baud_sel;
    logic       tick_en;
    logic       bit_tick;

    assign tick_en = (state != IDLE);

    uart_tx_baud_tick #(
        .CLK_FREQ(CLK_FREQ),
        .DIV_W   (DIV_W)
    ) u_baud_tick (
        .Clock   (Clock),
        .Reset   (Reset),
        .enable  (tick_en),
        .baud_sel(baud_sel),
        .BitTick (bit_tick)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            par_bit  <= 1'b1;
            baud_sel <= BAUD_2400;
            DataTx   <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    DataTx <= 1'b1;
                    if (Send) begin
                        // Parity is resolved at accept so later ParityType changes cannot leak in.
                        shreg    <= DataIn;
                        par_bit  <= parity_bit(DataIn, ParityType);
                        baud_sel <= BaudRate;
                        bit_cnt  <= '0;
                        DataTx   <= 1'b0;
                        Busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        DataTx <= shreg[0];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            DataTx <= par_bit;
                            state  <= PARITY;
                        end else begin
                            shreg   <= shreg >> 1;
                            DataTx  <= shreg[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        DataTx <= 1'b1;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    DataTx <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: a scaled-clock instance for most scenarios, a 50 MHz instance for exact timing.
module tb_uart_tx_unit;

    localparam int F_SMALL = 96000;
    localparam int F_BIG   = 50000000;

    logic       clk = 1'b0;
    logic       rst, send, tx, busy, done;
    logic [7:0] din;
    logic [1:0] ptype, brate;
    logic       rst50, send50, tx50, busy50, done50;
    logic [7:0] din50;
    logic [1:0] pt50, br50;

    int   n_cmp = 0;
    int   n_err = 0;
    logic cap_bits [11];
    int   busy_cnt, done_cnt, done_k;
    logic last_tx;
    int   chg [$];

    always #5 clk = ~clk;

    uart_tx_unit #(.CLK_FREQ(F_SMALL), .DIV_W(15)) dut (
        .Clock(clk), .Reset(rst), .Send(send), .DataIn(din), .ParityType(ptype),
        .BaudRate(brate), .DataTx(tx), .Busy(busy), .Done(done)
    );

    uart_tx_unit #(.CLK_FREQ(F_BIG), .DIV_W(15)) dut50 (
        .Clock(clk), .Reset(rst50), .Send(send50), .DataIn(din50), .ParityType(pt50),
        .BaudRate(br50), .DataTx(tx50), .Busy(busy50), .Done(done50)
    );

    function automatic int exp_div(input int f, input logic [1:0] br);
        int rate;
        rate = 2400 * (1 << br);
        return (f + rate / 2) / rate;
    endfunction

    // Frame bit b of the reference frame: start, data LSB-first, parity, stop.
    function automatic logic exp_bit(input int b, input logic [7:0] d, input logic [1:0] pt);
        int ones;
        ones = $countones(d);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9) begin
            if (pt == 2'b01) return (ones % 2) == 0;
            if (pt == 2'b10) return (ones % 2) == 1;
            return 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic start_frame(input bit sel50, input logic [7:0] d, input logic [1:0] pt,
                               input logic [1:0] br, input bit hold);
        @(negedge clk);
        if (sel50) begin din50 = d; pt50 = pt; br50 = br; send50 = 1'b1; end
        else begin din = d; ptype = pt; brate = br; send = 1'b1; end
        @(posedge clk);
        #1;
        if (!hold) begin send = 1'b0; send50 = 1'b0; end
    endtask

    // Samples `limit` cycles from the accept edge; k counts cycles of the frame.
    task automatic capture(input bit sel50, input int div, input int limit, input int mut_k,
                           input logic [7:0] mut_d, input logic [1:0] mut_br, input int pulse_k);
        logic prev, cur;
        busy_cnt = 0; done_cnt = 0; done_k = -1; prev = 1'b0;
        chg.delete();
        for (int b = 0; b < 11; b++) cap_bits[b] = 1'bx;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            cur = sel50 ? tx50 : tx;
            if (cur !== prev) chg.push_back(k);
            prev = cur;
            if ((k % div) == div / 2 && (k / div) < 11) cap_bits[k/div] = cur;
            if ((sel50 ? busy50 : busy) === 1'b1) busy_cnt++;
            if ((sel50 ? done50 : done) === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == mut_k) begin
                if (sel50) begin din50 = mut_d; br50 = mut_br; end
                else begin din = mut_d; brate = mut_br; end
            end
            if (pulse_k >= 0 && k == pulse_k) send = 1'b1;
            if (pulse_k >= 0 && k == pulse_k + 1) send = 1'b0;
        end
        last_tx = prev;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst50 = 1'b1;
        send = 0; din = 0; ptype = 0; brate = 0;
        send50 = 0; din50 = 0; pt50 = 0; br50 = 0;
        #12;
        n_cmp++;
        if ({tx, busy, done} !== 3'b100) begin
            n_err++; $display("FAIL reset_state: got %b want 100", {tx, busy, done});
        end
        n_cmp++;
        if ({tx50, busy50, done50} !== 3'b100) begin
            n_err++; $display("FAIL reset_state50: got %b want 100", {tx50, busy50, done50});
        end
        @(negedge clk); rst = 1'b0; rst50 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_50m;
        logic ref_bits [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        start_frame(1, 8'hA5, 2'b10, 2'b11, 0);
        capture(1, 2604, 11 * 2604 + 1, -1, 8'h00, 2'b11, -1);
        for (int b = 0; b < 11; b++) begin
            n_cmp++;
            if (cap_bits[b] !== ref_bits[b]) begin
                n_err++; $display("FAIL a5_bit%0d: got %b want %b", b, cap_bits[b], ref_bits[b]);
            end
        end
        n_cmp++;
        if (busy_cnt != 28644) begin
            n_err++; $display("FAIL a5_busy_len: got %0d want 28644", busy_cnt);
        end
        n_cmp++;
        if (done_cnt != 1 || done_k != 28644) begin
            n_err++; $display("FAIL a5_done: got %0d pulses at %0d want 1 at 28644", done_cnt, done_k);
        end
    endtask

    task automatic test_parity;
        logic [1:0] pts [4] = '{2'b01, 2'b01, 2'b00, 2'b11};
        logic [7:0] ds  [4];
        logic       exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        ds[0] = 8'h00; ds[1] = 8'h01;
        ds[2] = 8'($urandom); ds[3] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            start_frame(0, ds[i], pts[i], 2'b11, 0);
            capture(0, 5, 11 * 5 + 1, -1, 8'h00, 2'b11, -1);
            n_cmp++;
            if (cap_bits[9] !== exp[i]) begin
                n_err++;
                $display("FAIL parity pt=%b d=%h: got %b want %b", pts[i], ds[i], cap_bits[9], exp[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic [1:0] pt, br;
        int div, bad;
        for (int f = 0; f < 12; f++) begin
            d = 8'($urandom); pt = 2'($urandom); br = 2'($urandom);
            div = exp_div(F_SMALL, br);
            start_frame(0, d, pt, br, 0);
            n_cmp++;
            if (tx !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL rnd_latency %0d: got tx=%b busy=%b want 0 1", f, tx, busy);
            end
            capture(0, div, 11 * div + 1, -1, 8'h00, br, -1);
            bad = 0;
            for (int b = 0; b < 11; b++) if (cap_bits[b] !== exp_bit(b, d, pt)) bad++;
            n_cmp++;
            if (bad != 0) begin
                n_err++; $display("FAIL rnd_frame %0d d=%h pt=%b br=%b: %0d bits wrong want 0", f, d, pt, br, bad);
            end
            n_cmp++;
            if (busy_cnt != 11 * div || done_cnt != 1 || done_k != 11 * div) begin
                n_err++;
                $display("FAIL rnd_timing %0d: got busy=%0d done=%0d@%0d want busy=%0d done=1@%0d",
                         f, busy_cnt, done_cnt, done_k, 11 * div, 11 * div);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d0;
        logic [1:0] pt;
        int bad, idle_bad;
        d0 = 8'($urandom_range(0, 255));
        if (d0 == 8'h3C) d0 = 8'hC3;
        pt = 2'($urandom);
        start_frame(0, d0, pt, 2'b10, 1);
        capture(0, 10, 111, 35, 8'h3C, 2'b10, -1);
        bad = 0;
        for (int b = 0; b < 11; b++) if (cap_bits[b] !== exp_bit(b, d0, pt)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL b2b_first_frame: %0d bits wrong want 0", bad);
        end
        n_cmp++;
        if (last_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
            n_err++; $display("FAIL b2b_gap_cycle: got tx=%b busy=%b done=%b want 1 0 1", last_tx, busy, done);
        end
        @(posedge clk);
        #1;
        send = 1'b0;
        n_cmp++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL b2b_second_start: got tx=%b busy=%b want 0 1", tx, busy);
        end
        capture(0, 10, 111, -1, 8'h3C, 2'b10, 30);
        bad = 0;
        for (int b = 0; b < 11; b++) if (cap_bits[b] !== exp_bit(b, 8'h3C, pt)) bad++;
        n_cmp++;
        if (bad != 0 || done_cnt != 1) begin
            n_err++; $display("FAIL b2b_second_frame: %0d bits wrong, %0d done want 0, 1", bad, done_cnt);
        end
        idle_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        n_cmp++;
        if (idle_bad != 0) begin
            n_err++; $display("FAIL busy_send_queued: got %0d non-idle cycles want 0", idle_bad);
        end
    endtask

    task automatic test_baud_hold;
        int exp_chg [$];
        int bad;
        logic [1:0] pt;
        pt = 2'($urandom);
        for (int b = 1; b < 11; b++)
            if (exp_bit(b, 8'h55, pt) != exp_bit(b - 1, 8'h55, pt)) exp_chg.push_back(b * 40);
        start_frame(0, 8'h55, pt, 2'b00, 0);
        capture(0, 40, 11 * 40 + 1, 60, 8'h55, 2'b11, -1);
        bad = (chg.size() != exp_chg.size()) ? 1 : 0;
        if (bad == 0) for (int i = 0; i < chg.size(); i++) if (chg[i] != exp_chg[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL bit_edges_2400: got %0d edges want %0d at multiples of 40", chg.size(), exp_chg.size());
        end
        start_frame(1, 8'hFF, 2'b00, 2'b00, 0);
        capture(1, 20833, 20836, 100, 8'h00, 2'b11, -1);
        n_cmp++;
        if (chg.size() == 0 || chg[0] != 20833) begin
            n_err++; $display("FAIL start_bit_len_50m: got %0d want 20833", chg.size() == 0 ? -1 : chg[0]);
        end
        @(negedge clk); rst50 = 1'b1;
        @(negedge clk); rst50 = 1'b0;
    endtask

    task automatic test_reset_mid;
        int idle_bad;
        start_frame(0, 8'h00, 2'($urandom), 2'b01, 0);
        capture(0, 20, 65, -1, 8'h00, 2'b01, -1);
        n_cmp++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL mid_data_line: got tx=%b busy=%b want 0 1", tx, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx, busy, done} !== 3'b100) begin
            n_err++; $display("FAIL async_abort: got %b want 100", {tx, busy, done});
        end
        @(negedge clk); rst = 1'b0;
        idle_bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
        end
        n_cmp++;
        if (idle_bad != 0) begin
            n_err++; $display("FAIL post_reset_idle: got %0d bad cycles want 0", idle_bad);
        end
    endtask

    task automatic test_loopback;
        logic [7:0] bytes [4];
        logic [7:0] rx;
        logic [2:0] err;
        logic [1:0] pt, br;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            pt = 2'($urandom); br = 2'($urandom);
            start_frame(0, bytes[i], pt, br, 0);
            capture(0, exp_div(F_SMALL, br), 11 * exp_div(F_SMALL, br) + 1, -1, 8'h00, br, -1);
            for (int b = 0; b < 8; b++) rx[b] = cap_bits[b+1];
            err[0] = (cap_bits[0] !== 1'b0);
            err[1] = (cap_bits[10] !== 1'b1);
            err[2] = 1'b0;
            if (pt == 2'b01) err[2] = (^{rx, cap_bits[9]}) !== 1'b1;
            if (pt == 2'b10) err[2] = (^{rx, cap_bits[9]}) !== 1'b0;
            n_cmp++;
            if (rx !== bytes[i] || err !== 3'b000) begin
                n_err++;
                $display("FAIL loopback %h pt=%b br=%b: got data=%h err=%b want %h 000", bytes[i], pt, br, rx, err, bytes[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_frame_50m;
        test_parity;
        test_random;
        test_back_to_back;
        test_baud_hold;
        test_reset_mid;
        test_loopback;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
